// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: EX/MEM register, req/gnt/rvalid data-bus FSM, byte-lane steering and MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN: trap misaligned half/word accesses instead of issuing them.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] ex_store_data_i,
  input  logic [31:0] ex_pc_plus_4_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic        ex_mem_read_i,
  input  logic        ex_mem_write_i,
  input  logic        ex_reg_write_i,
  input  logic [1:0]  ex_mem_to_reg_i,
  output logic        mem_stall_o,
  output logic [4:0]  mem_rd_addr_o,
  output logic        mem_reg_write_o,
  output logic [31:0] mem_fwd_data_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  output logic [3:0]  dmem_be_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic        wb_reg_write_o,
  output logic [4:0]  wb_rd_addr_o,
  output logic [31:0] wb_data_o,
  output logic        misalign_o,
  output logic [31:0] misalign_addr_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state_reg;

  logic        valid_reg;
  logic [31:0] result_reg;
  logic [31:0] store_data_reg;
  logic [31:0] pc4_reg;
  logic [4:0]  rd_reg;
  logic [2:0]  funct3_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic        reg_write_reg;
  logic [1:0]  mem_to_reg_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg      <= 1'b0;
      result_reg     <= '0;
      store_data_reg <= '0;
      pc4_reg        <= '0;
      rd_reg         <= '0;
      funct3_reg     <= '0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      reg_write_reg  <= 1'b0;
      mem_to_reg_reg <= '0;
    end else if (!mem_stall_o) begin
      valid_reg      <= ex_valid_i;
      result_reg     <= ex_result_i;
      store_data_reg <= ex_store_data_i;
      pc4_reg        <= ex_pc_plus_4_i;
      rd_reg         <= ex_rd_addr_i;
      funct3_reg     <= ex_funct3_i;
      mem_read_reg   <= ex_mem_read_i;
      mem_write_reg  <= ex_mem_write_i;
      reg_write_reg  <= ex_reg_write_i;
      mem_to_reg_reg <= ex_mem_to_reg_i;
    end
  end

  logic is_mem, is_store, misaligned, mem_op, complete;
  logic [1:0] byte_off;

  assign byte_off = result_reg[1:0];
  assign is_mem   = valid_reg & (mem_read_reg | mem_write_reg);
  // read+write together is resolved as a store
  assign is_store = mem_write_reg;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = is_mem &
                      (((funct3_reg[1:0] == 2'b01) & byte_off[0]) |
                       (funct3_reg[1] & (byte_off != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  assign mem_op      = is_mem & ~misaligned;
  assign dmem_req_o  = mem_op & (state_reg != WAIT);
  assign complete    = is_store ? (dmem_req_o & dmem_gnt_i)
                                : ((state_reg == WAIT) & dmem_rvalid_i);
  assign mem_stall_o = mem_op & ~complete;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE, REQ: begin
          if (mem_op) begin
            if (dmem_gnt_i) state_reg <= is_store ? IDLE : WAIT;
            else            state_reg <= REQ;
          end else begin
            state_reg <= IDLE;
          end
        end
        WAIT:    if (dmem_rvalid_i) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = store_data_reg;
    case (funct3_reg[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << byte_off;
        lane_wdata = {4{store_data_reg[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << byte_off;
        lane_wdata = {2{store_data_reg[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = dmem_rdata_i >> {byte_off, 3'b000};
    load_data = dmem_rdata_i;
    case (funct3_reg)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: ;
    endcase
  end

  // bus outputs are forced to zero when no request is being driven
  assign dmem_we_o    = dmem_req_o & is_store;
  assign dmem_addr_o  = dmem_req_o ? {result_reg[31:2], 2'b00} : '0;
  assign dmem_wdata_o = dmem_req_o ? lane_wdata : '0;
  assign dmem_be_o    = dmem_req_o ? lane_be : '0;

  assign mem_rd_addr_o   = valid_reg ? rd_reg : 5'd0;
  assign mem_reg_write_o = valid_reg & reg_write_reg;
  assign mem_fwd_data_o  = (mem_to_reg_reg == 2'b10) ? pc4_reg : result_reg;

  logic        wb_fire;
  logic [31:0] wb_sel;

  assign wb_fire = valid_reg & ~mem_stall_o;

  always_comb begin
    case (mem_to_reg_reg)
      2'b01:   wb_sel = load_data;
      2'b10:   wb_sel = pc4_reg;
      default: wb_sel = result_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid_o     <= 1'b0;
      wb_reg_write_o <= 1'b0;
      wb_rd_addr_o   <= '0;
      wb_data_o      <= '0;
    end else begin
      wb_valid_o     <= wb_fire;
      wb_reg_write_o <= wb_fire & reg_write_reg & (rd_reg != 5'd0) & ~misaligned;
      wb_rd_addr_o   <= wb_fire ? rd_reg : 5'd0;
      wb_data_o      <= wb_fire ? wb_sel : 32'd0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_o      <= 1'b0;
      misalign_addr_o <= '0;
    end else begin
      misalign_o      <= misaligned;
      misalign_addr_o <= misaligned ? result_reg : 32'd0;
    end
  end
`else
  assign misalign_o      = 1'b0;
  assign misalign_addr_o = '0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; define MEM_ALIGN_CHECK_EN to exercise the trap path.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid_i;
  logic [31:0] ex_result_i, ex_store_data_i, ex_pc_plus_4_i;
  logic [4:0]  ex_rd_addr_i;
  logic [2:0]  ex_funct3_i;
  logic        ex_mem_read_i, ex_mem_write_i, ex_reg_write_i;
  logic [1:0]  ex_mem_to_reg_i;
  logic        mem_stall_o;
  logic [4:0]  mem_rd_addr_o;
  logic        mem_reg_write_o;
  logic [31:0] mem_fwd_data_o;
  logic        dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_gnt_i, dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o, wb_reg_write_o;
  logic [4:0]  wb_rd_addr_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic [31:0] misalign_addr_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_result_i(ex_result_i), .ex_store_data_i(ex_store_data_i),
    .ex_pc_plus_4_i(ex_pc_plus_4_i), .ex_rd_addr_i(ex_rd_addr_i), .ex_funct3_i(ex_funct3_i),
    .ex_mem_read_i(ex_mem_read_i), .ex_mem_write_i(ex_mem_write_i),
    .ex_reg_write_i(ex_reg_write_i), .ex_mem_to_reg_i(ex_mem_to_reg_i),
    .mem_stall_o(mem_stall_o), .mem_rd_addr_o(mem_rd_addr_o),
    .mem_reg_write_o(mem_reg_write_o), .mem_fwd_data_o(mem_fwd_data_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_reg_write_o(wb_reg_write_o),
    .wb_rd_addr_o(wb_rd_addr_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [31:0] res, input logic [31:0] sdata,
                        input logic [31:0] pc4, input logic [4:0] rd, input logic [2:0] f3,
                        input logic rd_en, input logic wr_en, input logic regw,
                        input logic [1:0] m2r);
    ex_valid_i      = v;
    ex_result_i     = res;
    ex_store_data_i = sdata;
    ex_pc_plus_4_i  = pc4;
    ex_rd_addr_i    = rd;
    ex_funct3_i     = f3;
    ex_mem_read_i   = rd_en;
    ex_mem_write_i  = wr_en;
    ex_reg_write_i  = regw;
    ex_mem_to_reg_i = m2r;
  endtask

  // Issue a load, hold gnt off for gw cycles, then wait rw cycles after the grant for rvalid.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] rdata, input logic [31:0] exp,
                         input int gw, input int rw);
    set_op(1'b1, addr, 32'h0, 32'h0, rd, f3, 1'b1, 1'b0, 1'b1, 2'b01);
    step();
    ex_valid_i   = 1'b0;
    ex_rd_addr_i = 5'd7;
    for (int i = 0; i < gw; i++) begin
      check({tag, " req_wait_gnt"}, dmem_req_o, 1);
      check({tag, " stall_wait_gnt"}, mem_stall_o, 1);
      step();
    end
    dmem_gnt_i = 1'b1;
    #1;
    check({tag, " req_gnt"}, dmem_req_o, 1);
    check({tag, " addr"}, dmem_addr_o, {addr[31:2], 2'b00});
    check({tag, " stall_gnt"}, mem_stall_o, 1);
    step();
    dmem_gnt_i = 1'b0;
    for (int i = 0; i < rw; i++) begin
      check({tag, " req_low_wait"}, dmem_req_o, 0);
      check({tag, " stall_wait_rv"}, mem_stall_o, 1);
      check({tag, " bubble"}, wb_valid_o, 0);
      check({tag, " held_rd"}, mem_rd_addr_o, rd);
      step();
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    #1;
    check({tag, " stall_rv"}, mem_stall_o, 0);
    step();
    dmem_rvalid_i = 1'b0;
    check({tag, " wb_valid"}, wb_valid_o, 1);
    check({tag, " wb_data"}, wb_data_o, exp);
    check({tag, " wb_rd"}, wb_rd_addr_o, rd);
    check({tag, " wb_reg_write"}, wb_reg_write_o, 1);
    step();
    check({tag, " wb_single"}, wb_valid_o, 0);
    $display("load %s addr=0x%08h rdata=0x%08h -> 0x%08h", tag, addr, rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h0;
    set_op(1'b1, 32'h1234, 32'h0, 32'h0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00);
    repeat (3) step();
    check("rst wb_valid", wb_valid_o, 0);
    check("rst wb_data", wb_data_o, 0);
    check("rst wb_rd", wb_rd_addr_o, 0);
    check("rst dmem_req", dmem_req_o, 0);
    check("rst dmem_be", dmem_be_o, 0);
    check("rst stall", mem_stall_o, 0);
    check("rst mem_rd", mem_rd_addr_o, 0);
    check("rst mem_regw", mem_reg_write_o, 0);
    check("rst fwd", mem_fwd_data_o, 0);
    check("rst misalign", misalign_o, 0);
    $display("reset: outputs checked");

    // ADD captured at the release edge
    rst_n = 1'b1;
    step();
    ex_valid_i = 1'b0;
    check("add mem_rd", mem_rd_addr_o, 5);
    check("add mem_regw", mem_reg_write_o, 1);
    check("add fwd", mem_fwd_data_o, 32'h1234);
    check("add req", dmem_req_o, 0);
    check("add stall", mem_stall_o, 0);
    check("add wb_early", wb_valid_o, 0);
    step();
    check("add wb_valid", wb_valid_o, 1);
    check("add wb_rd", wb_rd_addr_o, 5);
    check("add wb_data", wb_data_o, 32'h1234);
    check("add wb_regw", wb_reg_write_o, 1);
    step();
    check("add wb_once", wb_valid_o, 0);
    $display("alu add rd=5 -> 0x00001234");

    // JAL-style link writeback
    set_op(1'b1, 32'h999, 32'h0, 32'h2004, 5'd1, 3'b000, 1'b0, 1'b0, 1'b1, 2'b10);
    step();
    ex_valid_i = 1'b0;
    check("jal fwd", mem_fwd_data_o, 32'h2004);
    step();
    check("jal wb_data", wb_data_o, 32'h2004);
    $display("alu link -> 0x00002004");

    // write to x0 must not assert reg_write
    set_op(1'b1, 32'h55, 32'h0, 32'h0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00);
    step();
    ex_valid_i = 1'b0;
    step();
    check("x0 wb_valid", wb_valid_o, 1);
    check("x0 wb_regw", wb_reg_write_o, 0);
    $display("alu rd=x0 -> no reg write");

    // SB at 0x103, grant delayed two cycles
    set_op(1'b1, 32'h103, 32'hAB, 32'h0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 2'b00);
    step();
    ex_valid_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("sb req", dmem_req_o, 1);
      check("sb we", dmem_we_o, 1);
      check("sb addr", dmem_addr_o, 32'h100);
      check("sb be", dmem_be_o, 4'b1000);
      check("sb wdata", dmem_wdata_o, 32'hABABABAB);
      check("sb stall", mem_stall_o, 1);
      step();
    end
    dmem_gnt_i = 1'b1;
    #1;
    check("sb addr_gnt", dmem_addr_o, 32'h100);
    check("sb stall_gnt", mem_stall_o, 0);
    step();
    dmem_gnt_i = 1'b0;
    check("sb wb_valid", wb_valid_o, 1);
    check("sb wb_regw", wb_reg_write_o, 0);
    check("sb req_after", dmem_req_o, 0);
    $display("store sb addr=0x103 be=1000 wdata=0xababab ab");

    do_load("lb", 32'h102, 3'b000, 5'd3, 32'h00800000, 32'hFFFFFF80, 0, 0);
    do_load("lbu", 32'h102, 3'b100, 5'd3, 32'h00800000, 32'h00000080, 1, 0);
    do_load("lhu", 32'h102, 3'b101, 5'd4, 32'hBEEF0000, 32'h0000BEEF, 0, 1);
    do_load("lh", 32'h102, 3'b001, 5'd4, 32'h80010000, 32'hFFFF8001, 0, 0);
    do_load("lw", 32'h100, 3'b010, 5'd6, 32'hDEADBEEF, 32'hDEADBEEF, 0, 2);

    // reset while waiting for rvalid
    set_op(1'b1, 32'h100, 32'h0, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1, 2'b01);
    step();
    ex_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    step();
    dmem_gnt_i = 1'b0;
    check("rstwait stall_pre", mem_stall_o, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rstwait stall", mem_stall_o, 0);
    check("rstwait req", dmem_req_o, 0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = 32'h12345678;
    step();
    dmem_rvalid_i = 1'b0;
    check("rstwait wb_valid", wb_valid_o, 0);
    check("rstwait wb_regw", wb_reg_write_o, 0);
    check("rstwait stall_post", mem_stall_o, 0);
    $display("reset in wait: late rvalid ignored");

    // read and write both set behaves as a store
    set_op(1'b1, 32'h200, 32'h55AA55AA, 32'h0, 5'd2, 3'b010, 1'b1, 1'b1, 1'b0, 2'b00);
    step();
    ex_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    #1;
    check("rw we", dmem_we_o, 1);
    check("rw be", dmem_be_o, 4'b1111);
    check("rw wdata", dmem_wdata_o, 32'h55AA55AA);
    check("rw stall", mem_stall_o, 0);
    step();
    dmem_gnt_i = 1'b0;
    check("rw wb_valid", wb_valid_o, 1);
    $display("read+write -> store sw addr=0x200");

`ifdef MEM_ALIGN_CHECK_EN
    set_op(1'b1, 32'h102, 32'h0, 32'h0, 5'd8, 3'b010, 1'b1, 1'b0, 1'b1, 2'b01);
    step();
    ex_valid_i = 1'b0;
    check("mis req", dmem_req_o, 0);
    check("mis stall", mem_stall_o, 0);
    step();
    check("mis flag", misalign_o, 1);
    check("mis addr", misalign_addr_o, 32'h102);
    check("mis wb_valid", wb_valid_o, 1);
    check("mis wb_regw", wb_reg_write_o, 0);
    step();
    check("mis once", misalign_o, 0);
    $display("misaligned lw addr=0x102 trapped");
`else
    // without the check, SH at 0x103 goes out with a truncated lane mask
    set_op(1'b1, 32'h103, 32'h1234, 32'h0, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 2'b00);
    step();
    ex_valid_i = 1'b0;
    dmem_gnt_i = 1'b1;
    #1;
    check("sh req", dmem_req_o, 1);
    check("sh be", dmem_be_o, 4'b1000);
    check("sh wdata", dmem_wdata_o, 32'h12341234);
    step();
    dmem_gnt_i = 1'b0;
    check("sh wb_valid", wb_valid_o, 1);
    check("sh misalign", misalign_o, 0);
    $display("sh addr=0x103 be=1000 wdata=0x12341234");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
